serial_ripple_subtractor: RTL and testbench
===========================================

Name: serial_ripple_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: computes a - b - bin one bit per clock, LSB first, through a single full-subtractor cell and a registered borrow.
- It is the inverse-operation companion to the combinational ripple adders and trades WIDTH cycles of latency for one cell of logic.
- Operands enter through a valid/ready handshake; the result leaves through a second valid/ready handshake.
- Used in area-constrained datapaths that run beside the dataflow adders.

Parameters:
- WIDTH, 4, operand and difference width in bits; must be 2 or more.

Ports:
- clk  input  1  single clock, all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, bin are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow-in
- out_valid  output  1  diff and bout are valid
- out_ready  input  1  downstream accepts the result
- diff  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH
- bout  output  1  borrow-out, 1 iff a < b + bin (unsigned)

Behaviour:
- Reset: rst_n low asynchronously forces state IDLE. diff, bout, out_valid, bit counter, borrow register and shift registers all go to 0. in_ready reads 1 while in reset because it decodes IDLE.
- Reset in any state, including mid-RUN or DONE, aborts the operation. No result is produced. Operands in flight are discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1, out_valid=0. On an edge with in_valid=1, latch a and b into shift registers, load the borrow register with bin, clear the counter, go to RUN. Otherwise stay.
  - RUN: in_ready=0, out_valid=0. Each cycle take the operand LSBs x=a_sh[0], y=b_sh[0] and borrow br:
    - d = x^y^br
    - br_next = (~x & y) | (~(x^y) & br)
    - shift d into the diff register at the MSB (right shift)
    - right-shift both operand registers
    - increment the counter
  - After the cycle with counter = WIDTH-1, go to DONE and load bout from br_next.
  - DONE: out_valid=1, in_ready=0. diff and bout are stable. On an edge with out_ready=1, go to IDLE. Otherwise hold indefinitely.
- Latency: the accept edge is edge 0. RUN spans edges 1..WIDTH. out_valid is high after edge WIDTH. A back-to-back throughput is one result per WIDTH+2 cycles at best.
- in_valid, a, b and bin are ignored outside IDLE. Input changes while busy must not affect the result.
- Results accepted on an out_valid/out_ready edge are not repeated. diff and bout keep their last value after leaving DONE until the next result is loaded. Only out_valid qualifies them.
- No overlap between states: in_ready and out_valid are never high in the same cycle.
- Counter width is clog2(WIDTH)+1. It holds no stale value across operations because it is cleared on accept.
- Arithmetic matches the width-extended reference expression {bout, diff} = {1'b0,a} - {1'b0,b} - bin taken mod 2^(WIDTH+1), where bout is the inverted carry.

Test Plan:
- Basic: WIDTH=4, a=5, b=3, bin=0, out_ready=1 -> out_valid high 4 cycles after accept, diff=4'h2, bout=0, then in_ready returns high.
- Underflow: a=3, b=5, bin=0 -> diff=4'hE, bout=1. a=0, b=0, bin=1 -> diff=4'hF, bout=1. a=4'hF, b=4'hF, bin=1 -> diff=4'hF, bout=1.
- Exhaustive: all 512 combinations of a, b and bin, back-to-back -> every {bout, diff} equals the model a-b-bin mod 32, and in_ready/out_valid are never both high.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, toggling a, b and in_valid meanwhile -> diff/bout unchanged, in_ready=0, exactly one result accepted when out_ready rises.
- Reset mid-RUN: assert rst_n=0 asynchronously at counter=2 -> out_valid, diff, bout = 0 immediately. After release the block is in IDLE with in_ready=1, and a new a=9, b=2 yields diff=4'h7, bout=0.
- Parameter: WIDTH=8, a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1, out_valid after exactly 8 RUN cycles.

Source files
------------

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial a - b - bin through one full-subtractor cell, LSB first, one bit per clock.
// The result appears WIDTH cycles after accept and is held in DONE until out_ready is high; in_ready is high only in IDLE.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic x, y, d_bit, br_next, last_bit;

  always_comb begin
    x        = a_sh_q[0];
    y        = b_sh_q[0];
    d_bit    = x ^ y ^ br_q;
    br_next  = (~x & y) | (~(x ^ y) & br_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));

    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    diff_d    = diff_q;
    br_d      = br_q;
    bout_d    = bout_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d    = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d    = {1'b0, b_sh_q[WIDTH-1:1]};
        diff_sh_d = {d_bit, diff_sh_q[WIDTH-1:1]};
        br_d      = br_next;
        cnt_d     = cnt_q + CW'(1);
        // The visible result only changes once the final bit is in, so it stays stable while busy.
        if (last_bit) begin
          diff_d  = {d_bit, diff_sh_q[WIDTH-1:1]};
          bout_d  = br_next;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      diff_q    <= '0;
      br_q      <= 1'b0;
      bout_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      diff_q    <= diff_d;
      br_q      <= br_d;
      bout_q    <= bout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for serial_ripple_subtractor: vector table, exhaustive sweep, backpressure, mid-run reset, WIDTH=8 instance.
module tb_serial_ripple_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, bin, bout;
  logic [3:0] a, b, diff;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, bin8, bout8;
  logic [7:0] a8, b8, diff8;

  int checks = 0;
  int errors = 0;
  int n_accepted = 0;

  logic [4:0] exp_q[$];
  logic [4:0] mon_e;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  serial_ripple_subtractor #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout)
  );

  serial_ripple_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .bin(bin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .diff(diff8), .bout(bout8)
  );

  function automatic logic [4:0] model(int x, int y, int c);
    int r;
    r = x - y - c;
    return {1'(r < 0), 4'(r)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every consumed result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (in_ready && out_valid) begin
        errors++;
        $display("FAIL handshake_overlap: in_ready=1 out_valid=1 expected not both");
      end
    end
    if (out_valid && out_ready) begin
      n_accepted++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got %0h with empty scoreboard", {bout, diff});
      end else begin
        mon_e = exp_q.pop_front();
        if ({bout, diff} !== mon_e) begin
          errors++;
          $display("FAIL result a-b-bin: got {bout,diff}=%0h expected %0h", {bout, diff}, mon_e);
        end
      end
    end
  end

  task automatic send(input logic [3:0] va, input logic [3:0] vb, input logic vbin,
                      input logic [4:0] e, input bit push);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end
    in_valid = 1'b1;
    a = va;
    b = vb;
    bin = vbin;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int acc0;
    logic [4:0] held;

    vecs[0] = '{4'h5, 4'h3, 1'b0, 4'h2, 1'b0};
    vecs[1] = '{4'h3, 4'h5, 1'b0, 4'hE, 1'b1};
    vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1};
    vecs[3] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
    vecs[4] = '{4'h9, 4'h2, 1'b0, 4'h7, 1'b0};
    vecs[5] = '{4'hF, 4'h0, 1'b0, 4'hF, 1'b0};
    vecs[6] = '{4'h0, 4'hF, 1'b0, 4'h1, 1'b1};
    vecs[7] = '{4'h8, 4'h7, 1'b1, 4'h0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_diff_bout", 32'({bout, diff}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic transaction with latency measurement.
    send(vecs[0].a, vecs[0].b, vecs[0].bin, {vecs[0].bout, vecs[0].diff}, 1'b1);
    wait_out(lat);
    chk("basic_latency", 32'(lat), 32'd4);
    chk("basic_diff", 32'(diff), 32'h2);
    chk("basic_bout", 32'(bout), 32'd0);
    @(posedge clk); #1;
    chk("basic_in_ready_back", 32'(in_ready), 32'd1);
    drain();

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].bin, {vecs[i].bout, vecs[i].diff}, 1'b1);
    end
    drain();

    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          send(4'(ia), 4'(ib), 1'(ic), model(ia, ib, ic), 1'b1);
        end
      end
    end
    drain();

    // Backpressure: result must hold while inputs churn.
    out_ready = 1'b0;
    send(4'hC, 4'h5, 1'b0, model(12, 5, 0), 1'b1);
    wait_out(lat);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    held = {bout, diff};
    chk("bp_value", 32'(held), 32'(model(12, 5, 0)));
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'($urandom);
      a = 4'($urandom);
      b = 4'($urandom);
      bin = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_hold", 32'({bout, diff}), 32'(held));
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid_hold", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    acc0 = n_accepted;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_one_accept", 32'(n_accepted - acc0), 32'd1);
    chk("bp_out_valid_drop", 32'(out_valid), 32'd0);
    drain();

    // Asynchronous reset at counter=2 aborts the operation.
    send(4'h5, 4'h3, 1'b0, 5'h0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(4'h9, 4'h2, 1'b0, 5'h07, 1'b1);
    wait_out(lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    drain();

    // WIDTH=8 instance.
    in_valid8 = 1'b1;
    a8 = 8'h00;
    b8 = 8'h01;
    bin8 = 1'b0;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_latency", 32'(lat), 32'd8);
    chk("w8_diff", 32'(diff8), 32'hFF);
    chk("w8_bout", 32'(bout8), 32'd1);
    @(posedge clk); #1;
    chk("w8_in_ready_back", 32'(in_ready8), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
